// File: rtl/apb_timer_pkg.sv
// rtl/apb_timer_pkg.sv - register map, control layout and decode helper for apb_timer
package apb_timer_pkg;

    localparam logic [11:0] TIMER_CTRL = 12'h000;
    localparam logic [11:0] TIMER_PSC  = 12'h004;
    localparam logic [11:0] TIMER_CNT  = 12'h008;
    localparam logic [11:0] TIMER_CMP  = 12'h00C;
    localparam logic [11:0] TIMER_STAT = 12'h010;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AR_BIT     = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;
    localparam int STAT_MATCH_BIT  = 0;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } timer_ctrl_t;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_PSC,
        REG_CNT,
        REG_CMP,
        REG_STAT,
        REG_NONE
    } timer_reg_e;

    // Misaligned offsets never match a table entry, so they decode to REG_NONE.
    function automatic timer_reg_e decode_reg(input logic [11:0] off);
        case (off)
            TIMER_CTRL: return REG_CTRL;
            TIMER_PSC:  return REG_PSC;
            TIMER_CNT:  return REG_CNT;
            TIMER_CMP:  return REG_CMP;
            TIMER_STAT: return REG_STAT;
            default:    return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - shared APB bus bundle with master and slave views
interface apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_timer_prescaler.sv
// rtl/apb_timer_prescaler.sv - divide-by-(psc+1) tick generator for the timer counter
module apb_timer_prescaler #(
    parameter int PSC_WIDTH = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 en,
    input  logic                 clr,
    input  logic [PSC_WIDTH-1:0] psc,
    output logic                 tick
);

    localparam logic [PSC_WIDTH-1:0] PSC_ONE = PSC_WIDTH'(1);

    logic [PSC_WIDTH-1:0] psc_cnt;
    logic                 wrap;

    assign wrap = (psc_cnt == psc);

    // A tick is still issued in a clearing cycle; clr only restarts the phase.
    assign tick = en & wrap;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            psc_cnt <= '0;
        end else if (clr || !en || wrap) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PSC_ONE;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB compare-match timer with prescaler, one-shot/auto-reload and level irq
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int CNT_WIDTH      = 32,
    parameter int PSC_WIDTH      = 16
) (
    input  logic pclk,
    input  logic presetn,
    apb_if.slave apb,
    output logic irq_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    timer_ctrl_t              ctrl;
    timer_ctrl_t              ctrl_wdata;
    logic [PSC_WIDTH-1:0]     psc;
    logic [CNT_WIDTH-1:0]     cnt;
    logic [CNT_WIDTH-1:0]     cmp;
    logic                     match;

    timer_reg_e               reg_sel;
    logic                     access;
    logic                     addr_err;
    logic                     wr_access;
    logic                     rd_access;
    logic                     we_ctrl;
    logic                     we_psc;
    logic                     we_cnt;
    logic                     we_cmp;
    logic                     we_stat;
    logic                     tick;
    logic                     hit;
    logic [APB_DATA_WIDTH-1:0] rdata;

    // Gating with presetn keeps the bus quiet while reset is held.
    assign access  = apb.psel & apb.penable & presetn;
    assign reg_sel = decode_reg(apb.paddr[11:0]);

    assign addr_err = (reg_sel == REG_NONE)
                    | (apb.paddr[1:0] != 2'b00)
                    | (apb.paddr[APB_ADDR_WIDTH-1:12] != '0);

    assign wr_access = access &  apb.pwrite & ~addr_err;
    assign rd_access = access & ~apb.pwrite & ~addr_err;

    assign we_ctrl = wr_access & (reg_sel == REG_CTRL);
    assign we_psc  = wr_access & (reg_sel == REG_PSC);
    assign we_cnt  = wr_access & (reg_sel == REG_CNT);
    assign we_cmp  = wr_access & (reg_sel == REG_CMP);
    assign we_stat = wr_access & (reg_sel == REG_STAT);

    assign apb.pready  = access;
    assign apb.pslverr = access & addr_err;
    assign apb.prdata  = rd_access ? rdata : '0;

    always_comb begin
        ctrl_wdata             = '0;
        ctrl_wdata.en          = apb.pwdata[CTRL_EN_BIT];
        ctrl_wdata.auto_reload = apb.pwdata[CTRL_AR_BIT];
        ctrl_wdata.irq_en      = apb.pwdata[CTRL_IRQ_EN_BIT];
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[CTRL_EN_BIT]     = ctrl.en;
                rdata[CTRL_AR_BIT]     = ctrl.auto_reload;
                rdata[CTRL_IRQ_EN_BIT] = ctrl.irq_en;
            end
            REG_PSC:  rdata[PSC_WIDTH-1:0] = psc;
            REG_CNT:  rdata[CNT_WIDTH-1:0] = cnt;
            REG_CMP:  rdata[CNT_WIDTH-1:0] = cmp;
            REG_STAT: rdata[STAT_MATCH_BIT] = match;
            default:  rdata = '0;
        endcase
    end

    apb_timer_prescaler #(
        .PSC_WIDTH (PSC_WIDTH)
    ) u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (ctrl.en),
        .clr     (we_ctrl | we_psc | we_cnt),
        .psc     (psc),
        .tick    (tick)
    );

    // Compare uses the registered cmp, so a same-cycle CMP write only affects later ticks.
    assign hit = tick & (cnt == cmp);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ctrl  <= '0;
            psc   <= '0;
            cnt   <= '0;
            cmp   <= '0;
            match <= 1'b0;
        end else begin
            if (we_ctrl) begin
                ctrl <= ctrl_wdata;
            end else if (hit && !ctrl.auto_reload) begin
                ctrl.en <= 1'b0;
            end

            if (we_psc) begin
                psc <= apb.pwdata[PSC_WIDTH-1:0];
            end

            if (we_cnt) begin
                cnt <= apb.pwdata[CNT_WIDTH-1:0];
            end else if (hit) begin
                if (ctrl.auto_reload) begin
                    cnt <= '0;
                end
            end else if (tick) begin
                cnt <= cnt + CNT_ONE;
            end

            if (we_cmp) begin
                cmp <= apb.pwdata[CNT_WIDTH-1:0];
            end

            // Setting has priority over a concurrent write-1-to-clear.
            if (hit) begin
                match <= 1'b1;
            end else if (we_stat && apb.pwdata[STAT_MATCH_BIT]) begin
                match <= 1'b0;
            end
        end
    end

    assign irq_o = match & ctrl.irq_en;

endmodule
